// File: rtl/ebpf_mem_pkg.sv
// ebpf_mem_pkg: shared FSM state, byte-enable width and byte-merge helper for BRAM port masters
package ebpf_mem_pkg;
   typedef enum logic {IDLE, RMW} state_e;
   localparam int MAX_DW = 1024;
   function automatic int be_width(input int dw);
      return dw / 8;
   endfunction
   // Words narrower than MAX_DW are zero-extended by the caller and truncated on return
   function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                    input logic [MAX_DW-1:0] new_w,
                                                    input logic [MAX_DW/8-1:0] be);
      logic [MAX_DW-1:0] w;
      w = old_w;
      for (int i = 0; i < MAX_DW / 8; i++) if (be[i]) w[i*8 +: 8] = new_w[i*8 +: 8];
      return w;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push and pop may coincide at any occupancy
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WIDTH-1:0]               din,
   input  logic                           pop,
   output logic [WIDTH-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic do_pop;
   always_comb begin
      do_pop  = pop && count_q != '0;
      wr_d    = push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d    = do_pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
      count_d = count_q + CW'(push) - CW'(do_pop);
      dout    = mem_q[rd_q];
      count   = count_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) if (push) mem_q[wr_q] <= din;
   always_ff @(posedge clk) if (!rst && push && !do_pop) assert (count_q != CW'(DEPTH)) else $error("sync_fifo overflow");
endmodule

// File: rtl/bram_port_master.sv
// bram_port_master: turns a load/store request stream into BRAM port cycles, with RMW for partial stores
module bram_port_master
   import ebpf_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int RESP_DEPTH = 4,
   localparam int BE_WIDTH  = be_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [BE_WIDTH-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);
   localparam int CW = $clog2(RESP_DEPTH + 1);
   state_e state_q, state_d;
   logic rd_inflight_q, rd_inflight_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [BE_WIDTH-1:0] be_q, be_d;
   logic [CW-1:0] fifo_count;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic accept, rmw, full_be, no_be;
   always_comb begin
      rmw           = state_q == RMW;
      full_be       = &req_be;
      no_be         = req_be == '0;
      // Space is reserved for the load whose data is still on the RAM output
      req_ready     = !rst && !rmw && ({1'b0, fifo_count} + (CW + 1)'(rd_inflight_q) < (CW + 1)'(RESP_DEPTH));
      accept        = req_valid && req_ready;
      rd_inflight_d = accept && !req_we;
      state_d       = accept && req_we && !full_be && !no_be ? RMW : IDLE;
      addr_d        = accept ? req_addr : addr_q;
      wdata_d       = accept ? req_wdata : wdata_q;
      be_d          = accept ? req_be : be_q;
      mem_en        = rmw ? !rst : accept && (!req_we || !no_be);
      mem_we        = rmw ? !rst : accept && req_we && full_be;
      mem_addr      = rmw ? addr_q : req_addr;
      mem_din       = rmw ? DATA_WIDTH'(byte_merge(MAX_DW'(mem_dout), MAX_DW'(wdata_q), (MAX_DW / 8)'(be_q))) : req_wdata;
      rsp_valid     = !rst && fifo_count != '0;
      rsp_rdata     = rsp_valid ? fifo_dout : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rd_inflight_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rd_inflight_q <= rd_inflight_d;
      end
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
   end
   sync_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(DATA_WIDTH)) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_inflight_q),
      .din   (mem_dout),
      .pop   (rsp_valid && rsp_ready),
      .dout  (fifo_dout),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_bram_port_master.sv
// tb_bram_port_master: directed checks of the BRAM port master against a 1-cycle WRITE_FIRST RAM model
module tb_bram_port_master;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
   logic [9:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0] req_be = '0;
   logic req_ready, rsp_valid, mem_en, mem_we;
   logic [31:0] rsp_rdata, mem_din, mem_dout;
   logic [9:0] mem_addr;
   logic [31:0] ram [1024];
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   always @(posedge clk) if (mem_en) begin
      if (mem_we) begin
         ram[mem_addr] <= mem_din;
         mem_dout <= mem_din;
      end else mem_dout <= ram[mem_addr];
   end
   bram_port_master dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic do_req(input logic we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
      #1;
      for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
      chk("req_accept", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask
   task automatic wait_rsp(input string tag, input logic [31:0] exp);
      for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
      chk("rsp_arrives", {31'b0, rsp_valid}, 32'd1);
      chk(tag, rsp_rdata, exp);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int acc, got, stalls, cyc, first, last;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      // Preload through full-word stores, back to back
      do_req(1, 10'd5, 32'hDEADBEEF, 4'hF);
      do_req(1, 10'd3, 32'h11223344, 4'hF);
      for (int i = 32; i < 48; i++) do_req(1, 10'(i), 32'hA000_0000 | i, 4'hF);
      @(negedge clk);
      // Load latency: accept N, rsp_valid N+2
      req_valid = 1; req_we = 0; req_addr = 10'd5;
      #1;
      chk("ld_ready", {31'b0, req_ready}, 32'd1);
      chk("ld_mem_en", {31'b0, mem_en}, 32'd1);
      chk("ld_mem_we", {31'b0, mem_we}, 32'd0);
      chk("ld_mem_addr", {22'b0, mem_addr}, 32'd5);
      @(negedge clk);
      req_valid = 0;
      chk("ld_n1_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("ld_n2_valid", {31'b0, rsp_valid}, 32'd1);
      chk("ld_n2_data", rsp_rdata, 32'hDEADBEEF);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      chk("ld_popped", {31'b0, rsp_valid}, 32'd0);
      // Partial store read-modify-write
      req_valid = 1; req_we = 1; req_addr = 10'd3; req_wdata = 32'hAABBCCDD; req_be = 4'b0101;
      #1;
      chk("rmw_rd_en", {31'b0, mem_en}, 32'd1);
      chk("rmw_rd_we", {31'b0, mem_we}, 32'd0);
      @(negedge clk);
      req_valid = 0;
      #1;
      chk("rmw_ready_low", {31'b0, req_ready}, 32'd0);
      chk("rmw_wr_en", {31'b0, mem_en}, 32'd1);
      chk("rmw_wr_we", {31'b0, mem_we}, 32'd1);
      chk("rmw_wr_addr", {22'b0, mem_addr}, 32'd3);
      chk("rmw_wr_din", mem_din, 32'h11BB33DD);
      @(negedge clk);
      chk("rmw_ready_back", {31'b0, req_ready}, 32'd1);
      do_req(0, 10'd3, 0, 0);
      wait_rsp("rmw_readback", 32'h11BB33DD);
      // Store then load to the same address on the next cycle
      do_req(1, 10'd7, 32'hCAFEF00D, 4'hF);
      do_req(0, 10'd7, 0, 0);
      wait_rsp("st_ld_hazard", 32'hCAFEF00D);
      // Empty byte mask: consumed without touching the RAM
      req_valid = 1; req_we = 1; req_addr = 10'd5; req_wdata = 32'h0; req_be = 4'b0000;
      #1;
      chk("be0_ready", {31'b0, req_ready}, 32'd1);
      chk("be0_mem_en", {31'b0, mem_en}, 32'd0);
      @(negedge clk);
      req_valid = 0;
      #1;
      chk("be0_mem_en_n1", {31'b0, mem_en}, 32'd0);
      chk("be0_ready_n1", {31'b0, req_ready}, 32'd1);
      do_req(0, 10'd5, 0, 0);
      wait_rsp("be0_unchanged", 32'hDEADBEEF);
      // Backpressure: 4 accepts then stall
      acc = 0; got = 0;
      rsp_ready = 0; req_we = 0;
      for (int c = 0; c < 6; c++) begin
         req_valid = acc < 8; req_addr = 10'(32 + acc);
         #1;
         if (req_valid && req_ready) acc++;
         @(negedge clk);
      end
      #1;
      chk("bp_accepts", acc, 32'd4);
      chk("bp_ready_low", {31'b0, req_ready}, 32'd0);
      rsp_ready = 1;
      for (int c = 0; c < 60 && got < 8; c++) begin
         req_valid = acc < 8; req_addr = 10'(32 + acc);
         #1;
         if (rsp_valid) begin
            chk($sformatf("bp_data%0d", got), rsp_rdata, 32'hA000_0020 + 32'(got));
            got++;
         end
         if (req_valid && req_ready) acc++;
         @(negedge clk);
      end
      req_valid = 0;
      #1;
      chk("bp_got", got, 32'd8);
      chk("bp_drained", {31'b0, rsp_valid}, 32'd0);
      // Streaming 16 loads with rsp_ready held high
      acc = 0; got = 0; stalls = 0; cyc = 0; first = -1; last = -1;
      for (int c = 0; c < 60 && got < 16; c++) begin
         req_valid = acc < 16; req_addr = 10'(32 + acc);
         #1;
         if (rsp_valid) begin
            chk($sformatf("st_data%0d", got), rsp_rdata, 32'hA000_0020 + 32'(got));
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         if (req_valid && !req_ready) stalls++;
         if (req_valid && req_ready) acc++;
         cyc++;
         @(negedge clk);
      end
      req_valid = 0;
      rsp_ready = 0;
      chk("st_got", got, 32'd16);
      chk("st_stalls", stalls, 32'd0);
      chk("st_span", last - first, 32'd15);
      // Reset during RMW with a response queued
      req_valid = 1; req_we = 0; req_addr = 10'd5;
      @(negedge clk);
      req_we = 1; req_wdata = 32'h0; req_be = 4'b0001;
      #1;
      chk("rr_store_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 0;
      rst = 1;
      #1;
      chk("rr_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rr_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      chk("rr_fifo_empty", {31'b0, rsp_valid}, 32'd0);
      chk("rr_ready_back", {31'b0, req_ready}, 32'd1);
      do_req(0, 10'd5, 0, 0);
      wait_rsp("rr_ram_unchanged", 32'hDEADBEEF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
